fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register that feed the decode stage, controller and hazard unit of the pipelined 19-bit processor.
- Holds the PC and drives the instruction-memory address.
- Computes the next PC from the redirect selected in ID.
- Keeps an 8-entry return-address stack (RAS) for call/return.
- Honours stall (pc_writebar, IF_ID_loadbar) and flush (IF_ID_flush) from the hazard unit.

---
 rtl/fetch_stage.sv | 191 +++++++++++++++++++
 tb/tb_fetch_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC selection, IF/ID pipeline register and
// an 8-entry return-address stack for the 19-bit pipelined processor.
// Instruction memory is combinational: imem_data reflects imem_addr in the
// same cycle.
module fetch_stage #(
  parameter int PC_W      = 12,
  parameter int INSTR_W   = 19,
  parameter int RAS_DEPTH = 8,
  parameter int OFF_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pc_writebar,
  input  logic               IF_ID_loadbar,
  input  logic               IF_ID_flush,
  input  logic [1:0]         pc_mux,
  input  logic               ras_push,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instruction,
  output logic [INSTR_W-1:0] IF_ID_instruction,
  output logic [PC_W-1:0]    IF_ID_pc,
  output logic               IF_ID_valid,
  output logic               ras_overflow,
  output logic               ras_underflow
);

  localparam int IDX_W = $clog2(RAS_DEPTH);
  // One extra bit so the pointer can hold RAS_DEPTH (stack full).
  localparam int PTR_W = IDX_W + 1;

  localparam logic [1:0] MUX_SEQ = 2'b00;
  localparam logic [1:0] MUX_BR  = 2'b01;
  localparam logic [1:0] MUX_JMP = 2'b10;
  localparam logic [1:0] MUX_RET = 2'b11;

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
  logic               ifid_valid_q, ifid_valid_d;

  logic [PTR_W-1:0]   ras_ptr_q, ras_ptr_d;
  logic [PC_W-1:0]    ras_mem_q [RAS_DEPTH];
  logic               ras_ovf_q, ras_ovf_d;
  logic               ras_unf_q, ras_unf_d;

  logic               ras_we;
  logic [IDX_W-1:0]   ras_widx;
  logic [PC_W-1:0]    ras_wdata;

  logic               ras_empty;
  logic               ras_full;
  logic [PTR_W-1:0]   ras_ptr_m1;
  logic [IDX_W-1:0]   ras_top_idx;
  logic [PC_W-1:0]    ras_top;

  logic [PC_W-1:0]    pc_seq;
  logic [PC_W-1:0]    pc_branch;
  logic [PC_W-1:0]    pc_jump;
  logic [PC_W-1:0]    ret_addr;
  logic [PC_W-1:0]    br_off;
  logic [1:0]         mux_eff;
  logic [PC_W-1:0]    pc_target;

  logic               ras_en;
  logic               do_push;
  logic               do_pop;

  assign imem_addr         = pc_q;
  assign instruction       = imem_data;
  assign IF_ID_instruction = ifid_instr_q;
  assign IF_ID_pc          = ifid_pc_q;
  assign IF_ID_valid       = ifid_valid_q;
  assign ras_overflow      = ras_ovf_q;
  assign ras_underflow     = ras_unf_q;

  // Stack status and the current top-of-stack (0 when empty).
  always_comb begin
    ras_empty   = (ras_ptr_q == '0);
    ras_full    = (ras_ptr_q == PTR_W'(RAS_DEPTH));
    ras_ptr_m1  = ras_ptr_q - PTR_W'(1);
    ras_top_idx = ras_ptr_m1[IDX_W-1:0];
    ras_top     = ras_empty ? '0 : ras_mem_q[ras_top_idx];
  end

  // Next-PC candidates and selection; a stale pc_mux behind a bubble is ignored.
  always_comb begin
    br_off    = {{(PC_W-OFF_W){ifid_instr_q[OFF_W-1]}}, ifid_instr_q[OFF_W-1:0]};
    pc_seq    = pc_q + PC_W'(1);
    ret_addr  = ifid_pc_q + PC_W'(1);
    pc_branch = ret_addr + br_off;
    pc_jump   = ifid_instr_q[PC_W-1:0];
    mux_eff   = ifid_valid_q ? pc_mux : MUX_SEQ;

    pc_target = pc_seq;
    case (mux_eff)
      MUX_SEQ: pc_target = pc_seq;
      MUX_BR:  pc_target = pc_branch;
      MUX_JMP: pc_target = pc_jump;
      MUX_RET: pc_target = ras_top;
      default: pc_target = pc_seq;
    endcase

    pc_d = pc_writebar ? pc_q : pc_target;
  end

  // IF/ID next state: flush beats hold beats load.
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    if (IF_ID_flush) begin
      ifid_instr_d = '0;
      ifid_pc_d    = '0;
      ifid_valid_d = 1'b0;
    end else if (!IF_ID_loadbar) begin
      ifid_instr_d = imem_data;
      ifid_pc_d    = pc_q;
      ifid_valid_d = 1'b1;
    end
  end

  // RAS update: acts only while the call/return in ID is valid and advancing,
  // so a stalled call or return takes effect exactly once.
  always_comb begin
    ras_en    = ifid_valid_q & ~IF_ID_loadbar;
    do_push   = ras_en & ras_push;
    do_pop    = ras_en & (pc_mux == MUX_RET);

    ras_ptr_d = ras_ptr_q;
    ras_ovf_d = ras_ovf_q;
    ras_unf_d = ras_unf_q;
    ras_we    = 1'b0;
    ras_widx  = ras_ptr_q[IDX_W-1:0];
    ras_wdata = ret_addr;

    if (do_push && do_pop) begin
      // Return target is the old top; the new return address replaces it.
      ras_we = 1'b1;
      if (ras_empty) begin
        ras_unf_d = 1'b1;
        ras_widx  = '0;
        ras_ptr_d = PTR_W'(1);
      end else begin
        ras_widx  = ras_top_idx;
      end
    end else if (do_push) begin
      if (ras_full) begin
        ras_ovf_d = 1'b1;
      end else begin
        ras_we    = 1'b1;
        ras_ptr_d = ras_ptr_q + PTR_W'(1);
      end
    end else if (do_pop) begin
      if (ras_empty) begin
        ras_unf_d = 1'b1;
      end else begin
        ras_ptr_d = ras_ptr_m1;
      end
    end
  end

  // PC, IF/ID, RAS pointer and sticky flags; reset overrides stall and redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= '0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
      ras_ptr_q    <= '0;
      ras_ovf_q    <= 1'b0;
      ras_unf_q    <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      ras_ptr_q    <= ras_ptr_d;
      ras_ovf_q    <= ras_ovf_d;
      ras_unf_q    <= ras_unf_d;
    end
  end

  // RAS storage has no reset; contents are only meaningful below the pointer.
  always_ff @(posedge clk) begin
    if (!reset && ras_we) begin
      ras_mem_q[ras_widx] <= ras_wdata;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a cycle table for reset, sequential fetch,
// stall/flush and branch/jump redirects, then hand-written RAS sequences.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, pc_writebar, IF_ID_loadbar, IF_ID_flush, ras_push;
  logic [1:0]  pc_mux;
  logic [11:0] imem_addr;
  logic [18:0] imem_data, instruction, IF_ID_instruction;
  logic [11:0] IF_ID_pc;
  logic        IF_ID_valid, ras_overflow, ras_underflow;

  logic [18:0] mem [4096];
  int n_cmp = 0;
  int n_bad = 0;

  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .pc_writebar(pc_writebar),
    .IF_ID_loadbar(IF_ID_loadbar), .IF_ID_flush(IF_ID_flush),
    .pc_mux(pc_mux), .ras_push(ras_push),
    .imem_addr(imem_addr), .imem_data(imem_data), .instruction(instruction),
    .IF_ID_instruction(IF_ID_instruction), .IF_ID_pc(IF_ID_pc),
    .IF_ID_valid(IF_ID_valid), .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow)
  );

  typedef struct {
    logic        rst, wb, lb, fl;
    logic [1:0]  mux;
    logic        push;
    logic [11:0] addr;
    logic [18:0] ii;
    logic [11:0] ipc;
    logic        iv, ovf, unf;
  } vec_t;

  vec_t vt [22];

  task automatic check(input string name, input int tag,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and leave time 1 past the edge.
  task automatic step(input logic rst, input logic wb, input logic lb,
                      input logic fl, input logic [1:0] mux, input logic push);
    reset = rst; pc_writebar = wb; IF_ID_loadbar = lb;
    IF_ID_flush = fl; pc_mux = mux; ras_push = push;
    @(posedge clk);
    #1;
  endtask

  task automatic normal();
    step(0, 0, 0, 0, 2'b00, 0);
  endtask

  // Return with flush of the wrong-path fetch, check target and underflow,
  // then one normal cycle so the target becomes a valid IF/ID entry.
  task automatic ret_check(input string name, input int tag,
                           input logic [11:0] tgt, input logic unf);
    step(0, 0, 0, 1, 2'b11, 0);
    check({name, " target"}, tag, 32'(imem_addr), 32'(tgt));
    check({name, " underflow"}, tag, 32'(ras_underflow), 32'(unf));
    normal();
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 19'(a + 'h100);
    mem[12'h009] = 19'h00010;   // jump to 0x010
    mem[12'h010] = 19'h000FC;   // branch offset -4
    mem[12'h00D] = 19'h00FFF;   // jump to 0xFFF
    mem[12'hFFF] = 19'h00001;   // branch offset +1

    //            rst wb lb fl mux    push addr     ii          ipc      iv ovf unf
    vt[0]  = '{1, 0, 0, 0, 2'b00, 0, 12'h000, 19'h00000, 12'h000, 0, 0, 0};
    vt[1]  = '{0, 0, 0, 0, 2'b00, 0, 12'h001, 19'h00100, 12'h000, 1, 0, 0};
    vt[2]  = '{0, 0, 0, 0, 2'b00, 0, 12'h002, 19'h00101, 12'h001, 1, 0, 0};
    vt[3]  = '{0, 0, 0, 0, 2'b00, 0, 12'h003, 19'h00102, 12'h002, 1, 0, 0};
    vt[4]  = '{0, 0, 0, 0, 2'b00, 0, 12'h004, 19'h00103, 12'h003, 1, 0, 0};
    vt[5]  = '{0, 0, 0, 0, 2'b00, 0, 12'h005, 19'h00104, 12'h004, 1, 0, 0};
    vt[6]  = '{0, 0, 0, 0, 2'b00, 0, 12'h006, 19'h00105, 12'h005, 1, 0, 0};
    vt[7]  = '{0, 0, 0, 0, 2'b00, 0, 12'h007, 19'h00106, 12'h006, 1, 0, 0};
    vt[8]  = '{0, 1, 1, 0, 2'b00, 0, 12'h007, 19'h00106, 12'h006, 1, 0, 0};
    vt[9]  = '{0, 1, 1, 0, 2'b00, 0, 12'h007, 19'h00106, 12'h006, 1, 0, 0};
    vt[10] = '{0, 0, 0, 1, 2'b00, 0, 12'h008, 19'h00000, 12'h000, 0, 0, 0};
    vt[11] = '{0, 0, 0, 0, 2'b00, 0, 12'h009, 19'h00108, 12'h008, 1, 0, 0};
    vt[12] = '{0, 0, 0, 0, 2'b00, 0, 12'h00A, 19'h00010, 12'h009, 1, 0, 0};
    vt[13] = '{0, 0, 0, 1, 2'b10, 0, 12'h010, 19'h00000, 12'h000, 0, 0, 0};
    vt[14] = '{0, 0, 0, 0, 2'b00, 0, 12'h011, 19'h000FC, 12'h010, 1, 0, 0};
    vt[15] = '{0, 0, 0, 1, 2'b01, 0, 12'h00D, 19'h00000, 12'h000, 0, 0, 0};
    vt[16] = '{0, 0, 0, 0, 2'b00, 0, 12'h00E, 19'h00FFF, 12'h00D, 1, 0, 0};
    vt[17] = '{0, 0, 0, 1, 2'b10, 0, 12'hFFF, 19'h00000, 12'h000, 0, 0, 0};
    vt[18] = '{0, 0, 0, 0, 2'b00, 0, 12'h000, 19'h00001, 12'hFFF, 1, 0, 0};
    vt[19] = '{0, 0, 0, 1, 2'b01, 0, 12'h001, 19'h00000, 12'h000, 0, 0, 0};
    vt[20] = '{0, 0, 0, 0, 2'b11, 0, 12'h002, 19'h00101, 12'h001, 1, 0, 0};
    vt[21] = '{1, 1, 1, 0, 2'b10, 1, 12'h000, 19'h00000, 12'h000, 0, 0, 0};

    reset = 1'b1; pc_writebar = 1'b0; IF_ID_loadbar = 1'b0;
    IF_ID_flush = 1'b0; pc_mux = 2'b00; ras_push = 1'b0;

    // Table-driven part.
    for (int i = 0; i < 22; i++) begin
      step(vt[i].rst, vt[i].wb, vt[i].lb, vt[i].fl, vt[i].mux, vt[i].push);
      check("imem_addr", i, 32'(imem_addr), 32'(vt[i].addr));
      check("IF_ID_instruction", i, 32'(IF_ID_instruction), 32'(vt[i].ii));
      check("IF_ID_pc", i, 32'(IF_ID_pc), 32'(vt[i].ipc));
      check("IF_ID_valid", i, 32'(IF_ID_valid), 32'(vt[i].iv));
      check("ras_overflow", i, 32'(ras_overflow), 32'(vt[i].ovf));
      check("ras_underflow", i, 32'(ras_underflow), 32'(vt[i].unf));
      check("instruction", i, 32'(instruction), 32'(mem[vt[i].addr]));
    end

    // Call/return: pushes at 0x020 and 0x030, then three returns.
    step(1, 0, 0, 0, 2'b00, 0);
    for (int i = 0; i < 33; i++) normal();
    check("call1 IF_ID_pc", 100, 32'(IF_ID_pc), 32'h020);
    step(0, 0, 0, 0, 2'b00, 1);
    for (int i = 0; i < 15; i++) normal();
    check("call2 IF_ID_pc", 101, 32'(IF_ID_pc), 32'h030);
    step(0, 0, 0, 0, 2'b00, 1);
    ret_check("ret1", 102, 12'h031, 1'b0);
    ret_check("ret2", 103, 12'h021, 1'b0);
    ret_check("ret3 empty", 104, 12'h000, 1'b1);
    check("callret overflow", 105, 32'(ras_overflow), 32'h0);

    // Overflow: nine pushes of 1..9, then push+pop at full, then drain.
    step(1, 0, 0, 0, 2'b00, 0);
    normal();
    for (int i = 1; i <= 9; i++) begin
      step(0, 0, 0, 0, 2'b00, 1);
      if (i == 8) check("ovf after 8", 200, 32'(ras_overflow), 32'h0);
      if (i == 9) check("ovf after 9", 201, 32'(ras_overflow), 32'h1);
    end
    step(0, 0, 0, 1, 2'b11, 1);
    check("push+pop full target", 202, 32'(imem_addr), 32'h008);
    normal();
    begin
      logic [11:0] exp_ret [8];
      exp_ret = '{12'h00A, 12'h007, 12'h006, 12'h005,
                  12'h004, 12'h003, 12'h002, 12'h001};
      for (int k = 0; k < 8; k++) ret_check("drain", 210 + k, exp_ret[k], 1'b0);
    end
    ret_check("drain empty", 220, 12'h000, 1'b1);
    check("drain overflow sticky", 221, 32'(ras_overflow), 32'h1);

    // Push+pop on an empty stack: target 0, underflow, one entry left.
    step(1, 0, 0, 0, 2'b00, 0);
    check("reset clears ovf", 300, 32'(ras_overflow), 32'h0);
    check("reset clears unf", 301, 32'(ras_underflow), 32'h0);
    normal();
    step(0, 0, 0, 1, 2'b11, 1);
    check("push+pop empty target", 302, 32'(imem_addr), 32'h000);
    check("push+pop empty unf", 303, 32'(ras_underflow), 32'h1);
    normal();
    ret_check("after empty push+pop", 304, 12'h001, 1'b1);
    ret_check("after empty push+pop 2", 305, 12'h000, 1'b1);

    // Stalled call: ras_push held through three stalled cycles counts once.
    step(1, 0, 0, 0, 2'b00, 0);
    normal();
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 2'b00, 1);
    check("stall addr", 400, 32'(imem_addr), 32'h001);
    check("stall IF_ID_pc", 401, 32'(IF_ID_pc), 32'h000);
    step(0, 0, 0, 0, 2'b00, 1);
    ret_check("stalled call ret", 402, 12'h001, 1'b0);
    ret_check("stalled call ret2", 403, 12'h000, 1'b1);
    check("stalled call ovf", 404, 32'(ras_overflow), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
